// File: rtl/decoder_proj_pkg.sv
// Shared encodings for the registered io_in decoder filter.
package decoder_proj_pkg;

  // Mode word driven alongside the select input.
  localparam logic [1:0] MODE_ONEHOT   = 2'd0;
  localparam logic [1:0] MODE_ONEHOT_N = 2'd1;
  localparam logic [1:0] MODE_THERM    = 2'd2;
  localparam logic [1:0] MODE_FREEZE   = 2'd3;

  // Filter FSM states.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_proj_decode.sv
// Combinational select/mode to decoded-word mapping.
module decoder_proj_decode
  import decoder_proj_pkg::*;
#(
  parameter  int IN_W  = 3,
  localparam int OUT_W = 2**IN_W
) (
  input  logic [IN_W-1:0]  i_sel,
  input  logic [1:0]       i_mode,
  output logic [OUT_W-1:0] o_dec
);

  logic [OUT_W-1:0] w_onehot;
  logic [OUT_W-1:0] w_therm;

  // Build one-hot and thermometer forms of the select word.
  always_comb begin
    w_onehot = '0;
    w_therm  = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_onehot[i] = (i == int'(i_sel));
      w_therm[i]  = (i <= int'(i_sel));
    end
  end

  // Pick the form requested by the mode; freeze has no decoded form.
  always_comb begin
    o_dec = '0;
    case (i_mode)
      MODE_ONEHOT:   o_dec = w_onehot;
      MODE_ONEHOT_N: o_dec = ~w_onehot;
      MODE_THERM:    o_dec = w_therm;
      MODE_FREEZE:   o_dec = '0;
      default:       o_dec = '0;
    endcase
  end

endmodule

// File: rtl/decoder_proj_filt.sv
// Glitch filter and registered decoder between the io_in pads and user logic.
// A {sel,mode} pair must hold for STABLE_CYCLES clocks after capture before
// it is decoded onto o_dec_out.
module decoder_proj_filt
  import decoder_proj_pkg::*;
#(
  parameter  int IN_W          = 3,
  parameter  int STABLE_CYCLES = 4,
  parameter  int CNT_W         = 8,
  localparam int OUT_W         = 2**IN_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [IN_W-1:0]  i_sel_in,
  input  logic [1:0]       i_mode,
  output logic [OUT_W-1:0] o_dec_out,
  output logic             o_out_valid,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_change_cnt
);

  // Stability counter only needs to reach STABLE_CYCLES-1; the next equal
  // sample is the commit itself.
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam int PAIR_W = IN_W + 2;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [PAIR_W-1:0] r_cand;
  logic [PAIR_W-1:0] w_cand_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [PAIR_W-1:0] r_comm;
  logic              r_have_commit;
  logic              w_commit;
  logic [PAIR_W-1:0] w_pair;
  logic [OUT_W-1:0]  w_dec;
  logic [OUT_W-1:0]  r_dec_out;
  logic              r_out_valid;
  logic              r_busy;
  logic [CNT_W-1:0]  r_change_cnt;

  assign w_pair = {i_sel_in, i_mode};

  decoder_proj_decode #(.IN_W(IN_W)) u_decode (
    .i_sel  (r_cand[PAIR_W-1:2]),
    .i_mode (r_cand[1:0]),
    .o_dec  (w_dec)
  );

  // Next-state logic: capture, settle and commit decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en && (i_mode != MODE_FREEZE) &&
            (!r_have_commit || (w_pair != r_comm))) begin
          w_state_nxt = ST_SETTLE;
          w_cand_nxt  = w_pair;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!i_en || (i_mode == MODE_FREEZE)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_pair != r_cand) begin
          w_cand_nxt = w_pair;
          w_cnt_nxt  = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, candidate and registered outputs; commit updates the decode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_cand        <= '0;
      r_cnt         <= '0;
      r_comm        <= '0;
      r_have_commit <= 1'b0;
      r_dec_out     <= '0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_change_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_commit;
      r_busy      <= (w_state_nxt == ST_SETTLE);
      if (w_commit) begin
        r_dec_out     <= w_dec;
        r_comm        <= r_cand;
        r_have_commit <= 1'b1;
        if (r_change_cnt != {CNT_W{1'b1}}) begin
          r_change_cnt <= r_change_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_dec_out    = r_dec_out;
  assign o_out_valid  = r_out_valid;
  assign o_busy       = r_busy;
  assign o_change_cnt = r_change_cnt;

endmodule

// File: doc/decoder_proj_filt.md
Name: decoder_proj_filt

Overview:
Parametrised, registered successor to the combinational io_in decoder. It samples a select word plus a mode, and requires the pair to be stable for STABLE_CYCLES clocks before committing. It then drives a registered decoded output (one-hot, active-low one-hot, or thermometer), pulses out_valid once per commit, and counts commits. It sits between the io_in pads and downstream user logic, filtering glitches that the asynchronous front end can present.

Parameters:
IN_W, 3, select width; decoded width OUT_W = 2**IN_W is a derived localparam, not overridable.
STABLE_CYCLES, 4, number of consecutive equal samples required after capture before commit; legal range 1..255.
CNT_W, 8, width of the saturating commit counter.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  filter enable.
sel_in  input  IN_W  select word to decode.
mode  input  2  0=one-hot, 1=one-hot active-low, 2=thermometer, 3=freeze.
dec_out  output  OUT_W  registered decoded value.
out_valid  output  1  one-cycle pulse on each commit.
busy  output  1  high while in SETTLE.
change_cnt  output  CNT_W  saturating count of commits.

Behaviour:
- Reset (async assert, sync release): state IDLE, dec_out=0, out_valid=0, busy=0, change_cnt=0, committed pair cleared, have_commit=0.
- States: IDLE, SETTLE. Stability counter is wide enough for STABLE_CYCLES.
- IDLE at an edge:
  - If en=1, mode!=3, and ({sel_in,mode} != committed pair or have_commit=0): capture the candidate, set cnt=0, go to SETTLE.
  - busy reads 1 from the following cycle.
- SETTLE at an edge, evaluated in priority order:
  - en=0 or mode=3: go to IDLE, discard the candidate, leave outputs unchanged.
  - {sel_in,mode} != candidate: recapture, cnt=0, stay in SETTLE.
  - Otherwise cnt++. When cnt reaches STABLE_CYCLES: commit and go to IDLE.
- Commit latency: capture at edge k with the input held through edges k+1..k+STABLE_CYCLES gives the commit at edge k+STABLE_CYCLES.
- On commit:
  - dec_out <= decode(candidate).
  - Committed pair <= candidate; have_commit <= 1.
  - out_valid=1 for exactly the next cycle.
  - change_cnt++, saturating at 2**CNT_W-1 with no wrap.
- Decode rules:
  - mode 0: bit sel set, all others 0.
  - mode 1: bitwise inverse of mode 0.
  - mode 2: bits [sel:0] set; sel=0 gives 1 bit, sel=OUT_W-1 gives all ones.
- A mode-only change counts as a change and triggers a new settle/commit.
- Freeze (mode 3): no captures are taken and dec_out holds its last committed value.
- Re-presenting the already-committed pair in IDLE does nothing: no pulse, no count.
- out_valid never stays high for two consecutive cycles, since at least one IDLE cycle separates commits.
- Reset asserted mid-SETTLE aborts immediately to the reset values; no partial commit.
- A new candidate captured the same cycle out_valid is high is legal.

Decomposition:
- decoder_proj_pkg holds:
  - the mode encodings (MODE_ONEHOT, MODE_ONEHOT_N, MODE_THERM, MODE_FREEZE);
  - the state enum (ST_IDLE, ST_SETTLE).
- One combinational sub-module, decoder_proj_decode, with parameter IN_W: maps (sel, mode) to OUT_W bits. It is reused by the formal wrapper.
- FSM, counters and registers stay in decoder_proj_filt.

Test Plan:
All scenarios use IN_W=3, STABLE_CYCLES=4.
- Reset, then en=1, sel_in=3'd5, mode=0 held -> after 4 further edges dec_out=8'b0010_0000, out_valid one cycle, change_cnt=1, busy low afterwards.
- Glitch: sel_in=5 for 2 edges, then 6 held -> no commit on 5; dec_out=8'b0100_0000 exactly 4 edges after the 6 was captured; change_cnt increments by 1 only.
- Mode only: committed sel=2 mode=0, switch to mode=2 -> dec_out=8'b0000_0111; then mode=1 -> 8'b1111_1011; each change pulses out_valid.
- Freeze and enable: mode=3 with sel changing -> dec_out held, busy=0. en dropped mid-SETTLE -> IDLE, no pulse, count unchanged.
- Saturation: CNT_W=2, alternate sel 0/1 across 5 commits -> change_cnt sticks at 3.
- Reset mid-SETTLE: assert rst_n=0 asynchronously two edges into SETTLE -> dec_out=0, change_cnt=0, busy=0 immediately. A re-presented sel commits normally after release.
